// File: rtl/mel_pkg.sv
// +---------------------------------------------------------------------------+
// | mel_pkg : shared constants and filter tables for the mel filterbank       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package mel_pkg;

  localparam int NF_DEF          = 512;
  localparam int Q_DEF           = 15;
  localparam int NUM_FILTERS_DEF = 26;
  localparam int ACC_W_DEF       = 40;
  localparam int MEL_IDX_W       = $clog2(NUM_FILTERS_DEF);

  // Edge bins e[0..M+1]; e[2]..e[3] spaced by 4 so its midpoint weight is exactly 0.5.
  localparam logic [15:0] MEL_EDGES [0:NUM_FILTERS_DEF+1] = '{
    16'd1,   16'd3,   16'd5,   16'd9,   16'd12,  16'd15,  16'd19,
    16'd23,  16'd27,  16'd32,  16'd37,  16'd43,  16'd49,  16'd56,
    16'd63,  16'd71,  16'd80,  16'd89,  16'd99,  16'd110, 16'd122,
    16'd135, 16'd149, 16'd164, 16'd181, 16'd199, 16'd218, 16'd240
  };

  // round(2^15 / (e[j+1]-e[j])), Q15
  localparam logic [15:0] MEL_RECIP [0:NUM_FILTERS_DEF] = '{
    16'd16384, 16'd16384, 16'd8192, 16'd10923, 16'd10923, 16'd8192,
    16'd8192,  16'd8192,  16'd6554, 16'd6554,  16'd5461,  16'd5461,
    16'd4681,  16'd4681,  16'd4096, 16'd3641,  16'd3641,  16'd3277,
    16'd2979,  16'd2731,  16'd2521, 16'd2341,  16'd2185,  16'd1928,
    16'd1820,  16'd1725,  16'd1489
  };

  localparam logic [31:0] MEL_SAT_MAX = 32'h7FFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mel_weight_mac.sv
// +---------------------------------------------------------------------------+
// | mel_weight_mac : rising and falling triangular weight products of a bin   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mel_weight_mac #(
  parameter int Q = 15
) (
  input  logic [30:0] p_i,
  input  logic [15:0] frac_i,
  output logic [31:0] rise_o,
  output logic [31:0] fall_o
);

  logic [16:0] w_fall_w;
  logic [47:0] w_rise_full;
  logic [47:0] w_fall_full;

  always_comb begin
    w_fall_w    = 17'(1 << Q) - 17'(frac_i);
    w_rise_full = (48'(p_i) * 48'(frac_i)) >> Q;
    w_fall_full = (48'(p_i) * 48'(w_fall_w)) >> Q;
    rise_o      = (|w_rise_full[47:32]) ? '1 : w_rise_full[31:0];
    fall_o      = (|w_fall_full[47:32]) ? '1 : w_fall_full[31:0];
  end

endmodule

`default_nettype wire

// File: rtl/mel_filterbank.sv
// +---------------------------------------------------------------------------+
// | mel_filterbank : streaming triangular mel filterbank, 3-stage pipeline    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mel_filterbank
  import mel_pkg::*;
#(
  parameter int NF          = NF_DEF,
  parameter int Q           = Q_DEF,
  parameter int NUM_FILTERS = NUM_FILTERS_DEF,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [31:0]          periodogram_in,
  input  logic                        periodogram_valid,
  output logic signed [31:0]          mel_out,
  output logic [MEL_IDX_W-1:0]        mel_index,
  output logic                        mel_valid,
  output logic                        frame_done
);

  localparam int KW = $clog2(NF);
  localparam int SW = $clog2(NUM_FILTERS + 3);
  localparam int IW = MEL_IDX_W;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [31:0]      b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // seg_q counts edges already passed: region 0 is before e[0], s+1 is segment s.
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [15:0]   w_edge, w_off, w_frac;
  logic [SW-1:0] w_rgn, w_seg;
  logic [30:0]   w_p;
  logic          w_hit, w_in_seg, w_last;

  always_comb begin
    w_edge   = (seg_q <= SW'(NUM_FILTERS + 1)) ? MEL_EDGES[seg_q] : 16'hFFFF;
    w_hit    = (16'(k_q) == w_edge);
    w_rgn    = seg_q + SW'(w_hit);
    w_in_seg = (w_rgn != '0) && (w_rgn <= SW'(NUM_FILTERS + 1));
    w_seg    = w_in_seg ? (w_rgn - SW'(1)) : '0;
    w_off    = 16'(k_q) - MEL_EDGES[w_seg];
    w_frac   = w_in_seg ? (w_off * MEL_RECIP[w_seg]) : '0;
    w_p      = periodogram_in[31] ? '0 : periodogram_in[30:0];
    w_last   = (k_q == KW'(NF - 1));
    k_d      = k_q;
    seg_d    = seg_q;
    if (periodogram_valid) begin
      k_d   = w_last ? '0 : k_q + KW'(1);
      seg_d = w_last ? '0 : w_rgn;
    end
  end

  logic          s1_vld_q, s1_rise_en_q, s1_fall_en_q, s1_shift_q;
  logic          s1_emit_q, s1_done_q, s1_last_q;
  logic [30:0]   s1_p_q;
  logic [15:0]   s1_frac_q;
  logic [IW-1:0] s1_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q          <= '0;
      seg_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_rise_en_q <= 1'b0;
      s1_fall_en_q <= 1'b0;
      s1_shift_q   <= 1'b0;
      s1_emit_q    <= 1'b0;
      s1_done_q    <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_p_q       <= '0;
      s1_frac_q    <= '0;
      s1_idx_q     <= '0;
    end else begin
      k_q      <= k_d;
      seg_q    <= seg_d;
      s1_vld_q <= periodogram_valid;
      if (periodogram_valid) begin
        s1_p_q       <= w_p;
        s1_frac_q    <= w_frac;
        s1_rise_en_q <= w_in_seg && (w_seg < SW'(NUM_FILTERS));
        s1_fall_en_q <= w_in_seg && (w_seg != '0);
        s1_shift_q   <= w_hit;
        s1_emit_q    <= w_hit && (w_rgn >= SW'(3));
        s1_idx_q     <= IW'(w_rgn - SW'(3));
        s1_done_q    <= w_hit && (w_rgn == SW'(NUM_FILTERS + 2));
        s1_last_q    <= w_last;
      end
    end
  end

  logic [31:0]   w_rise_prod, w_fall_prod;

  mel_weight_mac #(.Q(Q)) u_mac (
    .p_i    (s1_p_q),
    .frac_i (s1_frac_q),
    .rise_o (w_rise_prod),
    .fall_o (w_fall_prod)
  );

  logic          s2_vld_q, s2_shift_q, s2_emit_q, s2_done_q, s2_last_q;
  logic [31:0]   s2_rise_q, s2_fall_q;
  logic [IW-1:0] s2_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q   <= 1'b0;
      s2_shift_q <= 1'b0;
      s2_emit_q  <= 1'b0;
      s2_done_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_rise_q  <= '0;
      s2_fall_q  <= '0;
      s2_idx_q   <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_rise_q  <= s1_rise_en_q ? w_rise_prod : '0;
        s2_fall_q  <= s1_fall_en_q ? w_fall_prod : '0;
        s2_shift_q <= s1_shift_q;
        s2_emit_q  <= s1_emit_q;
        s2_idx_q   <= s1_idx_q;
        s2_done_q  <= s1_done_q;
        s2_last_q  <= s1_last_q;
      end
    end
  end

  // acc_fall is emitted before the closing bin's own contributions are folded in.
  logic [ACC_W-1:0] acc_rise_q, acc_rise_d, acc_fall_q, acc_fall_d;
  logic [31:0]      w_emit_val;
  logic             w_emit;
  logic [31:0]      mel_out_q;
  logic [IW-1:0]    mel_index_q;
  logic             mel_valid_q, frame_done_q;

  always_comb begin
    acc_rise_d = acc_rise_q;
    acc_fall_d = acc_fall_q;
    w_emit     = s2_vld_q && s2_emit_q;
    w_emit_val = (acc_fall_q > ACC_W'(MEL_SAT_MAX)) ? MEL_SAT_MAX : acc_fall_q[31:0];
    if (s2_vld_q) begin
      if (s2_last_q) begin
        acc_rise_d = '0;
        acc_fall_d = '0;
      end else begin
        acc_fall_d = sat_add(s2_shift_q ? acc_rise_q : acc_fall_q, s2_fall_q);
        acc_rise_d = sat_add(s2_shift_q ? '0 : acc_rise_q, s2_rise_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_rise_q   <= '0;
      acc_fall_q   <= '0;
      mel_out_q    <= '0;
      mel_index_q  <= '0;
      mel_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      acc_rise_q   <= acc_rise_d;
      acc_fall_q   <= acc_fall_d;
      mel_valid_q  <= w_emit;
      frame_done_q <= w_emit && s2_done_q;
      if (w_emit) begin
        mel_out_q   <= w_emit_val;
        mel_index_q <= s2_idx_q;
      end
    end
  end

  assign mel_out    = $signed(mel_out_q);
  assign mel_index  = mel_index_q;
  assign mel_valid  = mel_valid_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mel_filterbank.sv
// +---------------------------------------------------------------------------+
// | tb_mel_filterbank : randomized self-checking bench with a behavioural model|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mel_filterbank;

  localparam int NF = 512;
  localparam int M  = 26;
  localparam longint ACC_MAX = (64'd1 << 40) - 1;
  localparam longint OUT_MAX = 64'h7FFF_FFFF;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [31:0] periodogram_in = '0;
  logic               periodogram_valid = 1'b0;
  logic signed [31:0] mel_out;
  logic [4:0]         mel_index;
  logic               mel_valid;
  logic               frame_done;

  mel_filterbank dut (
    .clk               (clk),
    .rst               (rst),
    .periodogram_in    (periodogram_in),
    .periodogram_valid (periodogram_valid),
    .mel_out           (mel_out),
    .mel_index         (mel_index),
    .mel_valid         (mel_valid),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int edges [0:M+1] = '{1, 3, 5, 9, 12, 15, 19, 23, 27, 32, 37, 43, 49, 56,
                        63, 71, 80, 89, 99, 110, 122, 135, 149, 164, 181, 199, 218, 240};
  int     recip [0:M];
  longint en [0:M-1];
  int     mk;

  typedef struct {
    int     due;
    int     idx;
    longint val;
    bit     done;
  } exp_t;
  exp_t expq[$];

  function automatic longint out_sat(input longint v);
    longint a;
    a = (v > ACC_MAX) ? ACC_MAX : v;
    return (a > OUT_MAX) ? OUT_MAX : a;
  endfunction

  task automatic model_reset();
    mk = 0;
    for (int i = 0; i < M; i++) en[i] = 0;
    expq.delete();
  endtask

  task automatic model_bin(input int p, input int due);
    longint pc;
    longint frac;
    exp_t   e;
    pc = (p < 0) ? 0 : p;
    for (int s = 2; s <= M + 1; s++) begin
      if (mk == edges[s]) begin
        e.due  = due;
        e.idx  = s - 2;
        e.val  = out_sat(en[s-2]);
        e.done = (s == M + 1);
        expq.push_back(e);
      end
    end
    for (int j = 0; j <= M; j++) begin
      if (mk >= edges[j] && mk < edges[j+1]) begin
        frac = longint'(mk - edges[j]) * recip[j];
        if (j < M)  en[j]   += (pc * frac) >>> 15;
        if (j >= 1) en[j-1] += (pc * (32768 - frac)) >>> 15;
      end
    end
    if (mk == NF - 1) begin
      mk = 0;
      for (int i = 0; i < M; i++) en[i] = 0;
    end else begin
      mk++;
    end
  endtask

  // ---------------- compare process ----------------
  longint cap [0:M-1];
  int     cap_cnt;
  int     done_cnt;
  longint last_val = 0;
  longint last_idx = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check(mel_valid == 1'b0 && frame_done == 1'b0, "reset_flags", {mel_valid, frame_done}, 0);
      check(mel_out == 0 && mel_index == 0, "reset_data", mel_out, 0);
      last_val = 0;
      last_idx = 0;
    end else if (mel_valid) begin
      if (expq.size() == 0) begin
        check(1'b0, "unexpected_emission", mel_index, -1);
      end else begin
        e = expq.pop_front();
        check(e.due == cyc, "emit_latency", cyc, e.due);
        check(mel_index == e.idx, "emit_index", mel_index, e.idx);
        check(longint'(mel_out) == e.val, "emit_value", mel_out, e.val);
        check(frame_done == e.done, "frame_done", frame_done, e.done);
      end
      if (frame_done) done_cnt++;
      cap[mel_index] = mel_out;
      cap_cnt++;
      last_val = mel_out;
      last_idx = mel_index;
    end else begin
      check(frame_done == 1'b0, "done_without_valid", frame_done, 0);
      check(longint'(mel_out) == last_val && longint'(mel_index) == last_idx,
            "hold_value", mel_out, last_val);
      if (expq.size() > 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        check(1'b0, "missing_emission", -1, e.idx);
      end
    end
  end

  // ---------------- stimulus ----------------
  int     fd [0:NF-1];
  longint cap_a [0:M-1];

  task automatic drive_bin(input int p);
    @(negedge clk);
    periodogram_valid = 1'b1;
    periodogram_in    = p;
    model_bin(p, cyc + 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      periodogram_valid = 1'b0;
      periodogram_in    = $urandom;
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < M; i++) cap[i] = -1;
    cap_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic run_frame(input int gap);
    clear_cap();
    for (int k = 0; k < NF; k++) begin
      drive_bin(fd[k]);
      if (gap > 0) idle(gap);
    end
    idle(8);
    check(expq.size() == 0, "queue_drained", expq.size(), 0);
    check(cap_cnt == M, "emission_count", cap_cnt, M);
    check(done_cnt == 1, "frame_done_count", done_cnt, 1);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < NF; k++) fd[k] = v;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NF; k++) begin
      if ($urandom_range(0, 7) == 0) fd[k] = -int'($urandom_range(1, 100000));
      else if ($urandom_range(0, 15) == 0) fd[k] = int'($urandom_range(0, 32'h7FFF_FFFF));
      else fd[k] = int'($urandom_range(0, 32'h00FF_FFFF));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    periodogram_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    idle(n);
    #2 rst = 1'b1;
  endtask

  initial begin
    for (int j = 0; j <= M; j++) begin
      recip[j] = (65536 / (edges[j+1] - edges[j]) + 1) / 2;
      if (recip[j] > 32767) recip[j] = 32767;
    end
    model_reset();
    clear_cap();
    idle(3);
    #2 rst = 1'b1;
    idle(2);

    // all-zero frame
    fill(0);
    run_frame(0);
    check(cap[0] == 0 && cap[M-1] == 0, "zero_frame_values", cap[M-1], 0);

    // impulse on the peak of filter 0
    fill(0);
    fd[3] = 32768;
    run_frame(0);
    check(cap[0] == 32768, "impulse_f0", cap[0], 32768);
    check(cap[1] == 0, "impulse_f1", cap[1], 0);

    // midpoint of segment 2: half weight to filters 1 and 2
    fill(0);
    fd[7] = 1000;
    run_frame(0);
    check(cap[2] == 500, "mid_f2", cap[2], 500);
    check(cap[1] == 500, "mid_f1", cap[1], 500);
    check(cap[3] == 0, "mid_f3", cap[3], 0);

    // full-scale input saturates
    fill(32'h7FFF_FFFF);
    run_frame(0);
    check(cap[0] == OUT_MAX, "sat_f0", cap[0], OUT_MAX);
    for (int i = 0; i < M; i++)
      check(cap[i] >= 0 && cap[i] <= OUT_MAX, "sat_range", cap[i], OUT_MAX);

    // negative input clamps
    fill(0);
    fd[3] = -5;
    run_frame(0);
    check(cap[0] == 0, "negative_clamp", cap[0], 0);

    // identical data, back-to-back then spaced by one idle cycle
    fill_random();
    run_frame(0);
    for (int i = 0; i < M; i++) cap_a[i] = cap[i];
    run_frame(1);
    for (int i = 0; i < M; i++) check(cap[i] == cap_a[i], "gap_vs_b2b", cap[i], cap_a[i]);

    // reset at bin 200, then a clean frame with no carry-over
    fill_random();
    run_frame(0);
    for (int i = 0; i < M; i++) cap_a[i] = cap[i];
    for (int k = 0; k < 200; k++) drive_bin(fd[k]);
    do_reset(4);
    idle(1);
    run_frame(0);
    for (int i = 0; i < M; i++) check(cap[i] == cap_a[i], "post_reset_frame", cap[i], cap_a[i]);

    idle(4);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mel_filterbank.md
Name: mel_filterbank

Overview:
- Streaming triangular mel filterbank in the MFCC front end. Sits directly downstream of periodogram_squared and consumes its power-spectrum stream, one bin per valid.
- Accumulates weighted bin power into NUM_FILTERS mel energies and emits each energy as soon as its filter support closes.
- Feeds the log/DCT stage.

Parameters:
- NF, 512, frame length in bins received per frame. Only bins 0..NF/2 can carry filter weight.
- Q, 15, fractional bits of the weights.
- NUM_FILTERS, 26, number of mel filters (M).
- ACC_W, 40, internal accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- periodogram_in  in  32 (signed)  bin power from periodogram_squared. Negative values are clamped to 0.
- periodogram_valid  in  1  one bin accepted per high cycle. There is no backpressure.
- mel_out  out  32 (signed)  mel energy, saturated to 2^31-1.
- mel_index  out  $clog2(NUM_FILTERS)  filter number of mel_out.
- mel_valid  out  1  one-cycle qualifier for mel_out and mel_index.
- frame_done  out  1  pulses together with the emission of filter M-1.

Behaviour:
- Reset (rst low, asynchronous): the following all clear to 0:
  - bin counter k, both accumulators, all pipeline valids;
  - mel_out, mel_index, mel_valid, frame_done.
  - A reset mid-frame discards the partial frame. The first valid after release is bin 0.
- Filter edges: table e[0..M+1] with 0 <= e[0] < e[1] < ... < e[M+1] <= NF/2.
  - Companion table recip[j] = min(32767, round(2^Q/(e[j+1]-e[j]))) for j = 0..M.
  - Filter m has support e[m] <= k < e[m+2] and peaks at e[m+1].
- Segment j holds e[j] <= k < e[j+1]. Within it:
  - frac = (k-e[j])*recip[j], Q15, unsigned 16 bits.
  - The rising contribution goes to filter j (if j<M): (P*frac)>>>Q.
  - The falling contribution goes to filter j-1 (if j>=1): (P*(2^Q-frac))>>>Q.
  - Bins with k<e[0] or k>=e[M+1] contribute nothing.
- Accumulators: acc_rise holds filter j and acc_fall holds filter j-1. Both are ACC_W bits, unsigned, and saturate at the maximum.
- Segment transition, on accepting the bin with k == e[j+1]:
  - Emit acc_fall as filter j-1 (if j>=1).
  - Move acc_rise to acc_fall.
  - Clear acc_rise.
  - Then add the current bin's contributions into the new pair.
  - When k == e[M+1], only filter M-1 is emitted, and frame_done pulses with it.
- Pipeline, 3 stages:
  - S1 registers the clamped P, k and the segment index, and computes frac.
  - S2 forms both products.
  - S3 accumulates and emits.
  - mel_valid rises exactly 3 cycles after the handshake of the closing bin.
- Throughput: a valid on every cycle is supported, and there is at most one emission per accepted bin.
- Bin counter k increments per valid and wraps NF-1 -> 0. On wrap both accumulators and the segment index clear, giving independent frames.
- Idle gaps between valids do not alter any state.
- Emission order is always 0..M-1 in every frame.
- Between emissions, mel_out and mel_index hold their last value.

Decomposition:
- Package mel_pkg holds:
  - NUM_FILTERS default, MEL_IDX_W;
  - edge table MEL_EDGES[0:M+1] (16-bit localparam array);
  - MEL_RECIP[0:M] (Q15);
  - the saturation limit constant.
- One natural sub-module: mel_weight_mac. It takes P and frac and returns both saturated products. It is instantiated in S2.
- Segment tracking, accumulators and emission stay in the top module.

Test Plan:
- Reset, then 512 zero bins -> exactly 26 emissions with indices 0..25 in order, all values 0, and frame_done together with index 25.
- Impulse: bin k=e[1] = 32768, all others 0 -> filter 0 = 32768, filters 1..25 = 0.
- Impulse at the midpoint of segment 2 with spacing 4, so frac=16384, value 1000 -> filter 2 = 500, filter 1 = 500, others 0.
- Constant 2^31-1 on every bin -> no wrap-around, and every emitted value saturates to at most 2^31-1. Also drive a negative input (-5) on bin e[1] alone -> filter 0 = 0.
- Back-to-back valids for one frame and 1-idle-cycle-spaced valids for a second frame with identical data -> identical mel_out sequences. mel_valid is exactly 3 cycles after each closing bin.
- rst asserted at bin 200, then a full new frame -> all outputs are 0 during reset, and the next frame's results match a clean-frame reference with no carry-over.
